// File: rtl/pwm_sine_pkg.sv
// Shared helpers for the sine PWM generator: tone-to-hold-count mapping and the
// elaboration-time sine duty table, built with fixed-point integer arithmetic.
package pwm_sine_pkg;

  localparam int     SIN_FRAC    = 32'sd30;
  localparam longint SIN_ONE     = 64'sd1073741824;
  localparam longint SIN_MASK    = 64'sd1073741823;
  localparam longint HALF_PI_FIX = 64'sd1686629713;

  function automatic int tone_to_n(input int base_n, input int step_n, input int tone);
    return base_n + tone * step_n;
  endfunction

  // sin(2*pi*k/depth) scaled by 2**SIN_FRAC; quadrant folding keeps the series near zero
  function automatic longint sin_fix(input int k, input int depth);
    longint ph;
    longint f;
    longint x;
    longint term;
    longint sum;
    int     quad;
    ph   = (longint'(k % depth) <<< 32'sd32) / longint'(depth);
    quad = int'(ph >>> SIN_FRAC);
    f    = ph & SIN_MASK;
    if ((quad == 32'sd1) || (quad == 32'sd3)) begin
      f = SIN_ONE - f;
    end else begin
      f = f;
    end
    x    = (f * HALF_PI_FIX) >>> SIN_FRAC;
    term = x;
    sum  = x;
    for (int n = 32'sd1; n <= 32'sd7; n++) begin
      term = (term * x) >>> SIN_FRAC;
      term = (term * x) >>> SIN_FRAC;
      term = -term / longint'((32'sd2 * n) * (32'sd2 * n + 32'sd1));
      sum  = sum + term;
    end
    return (quad >= 32'sd2) ? -sum : sum;
  endfunction

  function automatic int lut_val(input int r, input int depth, input int k);
    longint amp;
    longint v;
    amp = (64'sd1 <<< (r - 32'sd1)) - 64'sd1;
    v   = (64'sd1 <<< (r - 32'sd1 + SIN_FRAC)) + amp * sin_fix(k, depth) + (SIN_ONE >>> 32'sd1);
    return int'(v >>> SIN_FRAC);
  endfunction

endpackage

// File: rtl/pwm_sine_ch.sv
// One sine-PWM channel: hold counter, sample index, tone latch, duty register and
// the registered carrier comparator.
module pwm_sine_ch
  import pwm_sine_pkg::*;
#(
  parameter int R      = 6,
  parameter int DEPTH  = 36,
  parameter int NW     = 12,
  parameter int BASE_N = 1000,
  parameter int STEP_N = 200,
  parameter int IW     = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          wrap,
  input  logic [R-1:0]  carrier,
  input  logic [3:0]    tone,
  input  logic          mute,
  output logic          pwm,
  output logic          tick,
  output logic [IW-1:0] idx
);

  logic [R-1:0]  lut_tab [DEPTH];
  logic [NW-1:0] n_last_tab [16];
  logic [NW-1:0] hold;
  logic [3:0]    tone_l;
  logic [R-1:0]  duty;
  logic          sample_end;

  for (genvar k = 0; k < DEPTH; k++) begin : g_lut
    localparam int V = lut_val(R, DEPTH, k);
    assign lut_tab[k] = V[R-1:0];
  end

  // Last hold value per tone, so the boundary test is a plain equality
  for (genvar t = 0; t < 16; t++) begin : g_n
    localparam int NL = tone_to_n(BASE_N, STEP_N, t) - 32'sd1;
    assign n_last_tab[t] = NL[NW-1:0];
  end

  assign sample_end = (hold == n_last_tab[tone_l]);

  // Sequencer state moves only on an enabled carrier wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      hold   <= '0;
      idx    <= '0;
      tone_l <= 4'd0;
      duty   <= '0;
    end else if (en && wrap) begin
      duty <= lut_tab[idx];
      if (sample_end) begin
        hold   <= '0;
        idx    <= (idx == IW'(DEPTH - 1)) ? '0 : idx + 1'b1;
        tone_l <= tone;
      end else begin
        hold <= hold + 1'b1;
      end
    end else begin
      hold <= hold;
    end
  end

  // Registered output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm  <= 1'b0;
      tick <= 1'b0;
    end else begin
      pwm  <= en & ~mute & (carrier < duty);
      tick <= en & wrap & sample_end;
    end
  end

endmodule

// File: rtl/pwm_sine_multi.sv
// Multi-channel sine-modulated PWM: one shared carrier counter feeding NCH
// independent channel sequencers.
module pwm_sine_multi #(
  parameter int NCH    = 4,
  parameter int R      = 6,
  parameter int DEPTH  = 36,
  parameter int NW     = 12,
  parameter int BASE_N = 1000,
  parameter int STEP_N = 200,
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [4*NCH-1:0]  tone,
  input  logic [NCH-1:0]    mute,
  output logic [NCH-1:0]    pwm_out,
  output logic [NCH-1:0]    sample_tick,
  output logic [IW*NCH-1:0] sample_idx
);

  logic [R-1:0] carrier;
  logic         wrap;

  assign wrap = en & (carrier == {R{1'b1}});

  // Shared carrier, frozen while disabled
  always_ff @(posedge clk) begin
    if (rst) begin
      carrier <= '0;
    end else if (en) begin
      carrier <= carrier + 1'b1;
    end else begin
      carrier <= carrier;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pwm_sine_ch #(
      .R      (R),
      .DEPTH  (DEPTH),
      .NW     (NW),
      .BASE_N (BASE_N),
      .STEP_N (STEP_N),
      .IW     (IW)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .wrap    (wrap),
      .carrier (carrier),
      .tone    (tone[4*i +: 4]),
      .mute    (mute[i]),
      .pwm     (pwm_out[i]),
      .tick    (sample_tick[i]),
      .idx     (sample_idx[IW*i +: IW])
    );
  end

endmodule

// File: tb/tb_pwm_sine_multi.sv
// Self-checking bench for pwm_sine_multi: directed scenarios plus randomized
// traffic, every cycle compared against a behavioural model of the channel rules.
module tb_pwm_sine_multi;

  localparam int NCH    = 2;
  localparam int R      = 4;
  localparam int DEPTH  = 8;
  localparam int NW     = 6;
  localparam int BASE_N = 2;
  localparam int STEP_N = 1;
  localparam int IW     = 3;
  localparam int CPER   = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [7:0]    tone;
  logic [1:0]    mute;
  logic [1:0]    pwm_out;
  logic [1:0]    sample_tick;
  logic [5:0]    sample_idx;

  int n_cmp = 0;
  int n_bad = 0;

  int   m_car;
  int   m_hold [2];
  int   m_idx  [2];
  int   m_tone [2];
  int   m_duty [2];
  logic [1:0] e_pwm;
  logic [1:0] e_tick;
  int   lut [DEPTH];
  int   ref_tab [8] = '{8, 13, 15, 13, 8, 3, 1, 3};

  always #5 clk = ~clk;

  pwm_sine_multi #(
    .NCH(NCH), .R(R), .DEPTH(DEPTH), .NW(NW), .BASE_N(BASE_N), .STEP_N(STEP_N)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .tone(tone), .mute(mute),
    .pwm_out(pwm_out), .sample_tick(sample_tick), .sample_idx(sample_idx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_car  = 0;
    e_pwm  = 2'b00;
    e_tick = 2'b00;
    for (int i = 0; i < NCH; i++) begin
      m_hold[i] = 0; m_idx[i] = 0; m_tone[i] = 0; m_duty[i] = 0;
    end
  endtask

  // Apply the channel rules to the inputs present at the edge just taken
  task automatic model_step();
    if (rst) begin
      model_reset();
    end else if (!en) begin
      e_pwm  = 2'b00;
      e_tick = 2'b00;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        e_pwm[i]  = !mute[i] && (m_car < m_duty[i]);
        e_tick[i] = 1'b0;
        if (m_car == CPER - 1) begin
          m_duty[i] = lut[m_idx[i]];
          if (m_hold[i] == BASE_N + m_tone[i] * STEP_N - 1) begin
            m_hold[i] = 0;
            m_idx[i]  = (m_idx[i] + 1) % DEPTH;
            m_tone[i] = int'(tone[4*i +: 4]);
            e_tick[i] = 1'b1;
          end else begin
            m_hold[i] = m_hold[i] + 1;
          end
        end
      end
      m_car = (m_car + 1) % CPER;
    end
  endtask

  task automatic cyc(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      model_step();
      #1;
      check("pwm_out", 32'(pwm_out), 32'(e_pwm));
      check("sample_tick", 32'(sample_tick), 32'(e_tick));
      check("sample_idx", 32'(sample_idx), 32'({3'(m_idx[1]), 3'(m_idx[0])}));
    end
  endtask

  task automatic wait_tick(input int ch, input int budget, output int cycles);
    bit found = 1'b0;
    cycles = 0;
    while (!found && cycles < budget) begin
      cyc(1);
      cycles++;
      if (sample_tick[ch]) found = 1'b1;
    end
    if (!found) cycles = -1;
  endtask

  initial begin
    int c;
    int hi;
    int k;
    logic [1:0] acc_pwm;
    logic [1:0] acc_tick;
    logic [5:0] idx_save;

    for (int j = 0; j < DEPTH; j++) begin
      lut[j] = int'(real'(2 ** (R - 1)) + real'(2 ** (R - 1) - 1) * $sin(2.0 * 3.14159265358979 * j / DEPTH));
    end
    model_reset();
    rst = 1'b1; en = 1'b0; tone = 8'h00; mute = 2'b00;
    cyc(3);
    check("reset_pwm", 32'(pwm_out), 32'd0);
    check("reset_idx", 32'(sample_idx), 32'd0);

    // 1: release, no output before the first wrap, first advance after two wraps
    rst = 1'b0; en = 1'b1; tone = {4'd3, 4'd0};
    acc_pwm = 2'b00;
    for (int j = 0; j < CPER; j++) begin
      cyc(1);
      acc_pwm |= pwm_out;
    end
    check("pre_wrap_pwm", 32'(acc_pwm), 32'd0);
    wait_tick(0, 200, c);
    check("first_tick_ch0", c, 32'd16);
    check("first_tick_both", 32'(sample_tick), 32'd3);
    check("first_idx", 32'(sample_idx), 32'({3'd1, 3'd1}));

    // 2: ch1 with tone 3 holds 5 periods, ch0 holds 2; idx wraps 7 -> 0
    wait_tick(1, 200, c);
    check("ch1_period", c, 32'd80);
    wait_tick(0, 200, c);
    wait_tick(0, 200, c);
    check("ch0_period", c, 32'd32);
    for (int j = 0; j < 10 && sample_idx[2:0] != 3'd7; j++) wait_tick(0, 200, c);
    wait_tick(0, 200, c);
    check("wrap_period", c, 32'd32);
    check("idx_wrap", 32'(sample_idx[2:0]), 32'd0);

    // 3: tone change mid-sample applies at the next boundary only
    cyc(10);
    tone[3:0] = 4'd5;
    wait_tick(0, 200, c);
    check("tone_cur_sample", c, 32'd22);
    tone[3:0] = 4'd0;
    wait_tick(0, 300, c);
    check("tone_next_sample", c, 32'd112);

    // 4: mute ch1, sequencer keeps running
    mute = 2'b10;
    idx_save = sample_idx;
    acc_pwm = 2'b00;
    for (int j = 0; j < 200; j++) begin
      cyc(1);
      acc_pwm |= pwm_out;
    end
    check("mute_pwm1", 32'(acc_pwm[1]), 32'd0);
    check("mute_idx_moves", 32'(sample_idx[5:3] != idx_save[5:3]), 32'd1);
    mute = 2'b00;
    cyc(40);

    // 5: disable mid-carrier, everything freezes
    cyc(7);
    en = 1'b0;
    idx_save = sample_idx;
    acc_pwm = 2'b00; acc_tick = 2'b00;
    for (int j = 0; j < 50; j++) begin
      cyc(1);
      acc_pwm |= pwm_out;
      acc_tick |= sample_tick;
    end
    check("dis_pwm", 32'(acc_pwm), 32'd0);
    check("dis_tick", 32'(acc_tick), 32'd0);
    check("dis_idx", 32'(sample_idx), 32'(idx_save));
    en = 1'b1;
    cyc(40);

    // 6: duty sweep, high cycles per carrier period track the sine table
    wait_tick(0, 300, c);
    check("sweep_sync", 32'(c > 0), 32'd1);
    for (int s = 0; s < DEPTH; s++) begin
      k = int'(sample_idx[2:0]);
      cyc(CPER);
      hi = 0;
      for (int j = 0; j < CPER; j++) begin
        cyc(1);
        hi += int'(pwm_out[0]);
      end
      check("sweep_duty", hi, ref_tab[k]);
      check("sweep_tick", 32'(sample_tick[0]), 32'd1);
    end

    // Randomized traffic with enable gaps and one mid-run reset
    for (int j = 0; j < 900; j++) begin
      if (j % 37 == 0) begin
        tone = 8'($urandom);
        mute = 2'($urandom_range(0, 3));
      end
      en  = ($urandom_range(0, 9) < 8);
      rst = (j >= 450 && j < 452);
      cyc(1);
    end
    rst = 1'b0;
    en  = 1'b1;
    cyc(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
